// File: rtl/jzjpcc_fetch_pkg.sv
// jzjpcc_fetch_pkg: shared types and helpers for the fetch-stage PC and branch target buffer.
//   btb_entry_t : one BTB entry (valid, tag, target, 2-bit direction counter)
//   ctr_t       : 2-bit saturating direction counter
//   sat_update  : saturating counter step toward the resolved direction
package jzjpcc_fetch_pkg;
    // Tag and target fields are sized for the widest supported PC. Narrower
    // configurations zero-extend into them.
    localparam int PC_W_MAX = 32;
    localparam int FIELD_W = PC_W_MAX - 2;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_MIN = 2'b00;
    localparam ctr_t CTR_WEAK_TAKEN = 2'b10;
    localparam ctr_t CTR_MAX = 2'b11;

    typedef struct packed {
        logic valid;
        logic [FIELD_W-1:0] tag;
        logic [FIELD_W-1:0] target;
        ctr_t ctr;
    } btb_entry_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        return taken ? (ctr == CTR_MAX ? CTR_MAX : ctr + 2'd1)
                     : (ctr == CTR_MIN ? CTR_MIN : ctr - 2'd1);
    endfunction
endpackage

// File: rtl/jzjpcc_btb.sv
// jzjpcc_btb: direct-mapped branch target buffer with 2-bit direction counters.
//   clock, reset   : clock and asynchronous active-high reset (clears valid bits only)
//   lookup_pc      : PC[PC_WIDTH-1:2] looked up combinationally
//   lookup_taken   : entry hits and its counter predicts taken
//   lookup_target  : target stored in the indexed entry
//   update_*       : resolved control transfer, trains the BTB at the clock edge
//   flush          : invalidates every entry at the clock edge; beats update
module jzjpcc_btb
    import jzjpcc_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-3:0] lookup_pc,
    output logic                lookup_taken,
    output logic [PC_WIDTH-3:0] lookup_target,
    input  logic                update_valid,
    input  logic [PC_WIDTH-3:0] update_pc,
    input  logic [PC_WIDTH-3:0] update_target,
    input  logic                update_taken,
    input  logic                flush
);
    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t mem [BTB_ENTRIES];
    btb_entry_t rd, wr;
    logic [IDX-1:0] rd_idx, wr_idx;
    logic [FIELD_W-1:0] rd_tag, wr_tag;
    logic wr_hit;

    always_comb begin
        rd_idx = lookup_pc[IDX-1:0];
        wr_idx = update_pc[IDX-1:0];
        rd_tag = FIELD_W'(lookup_pc[PC_WIDTH-3:IDX]);
        wr_tag = FIELD_W'(update_pc[PC_WIDTH-3:IDX]);
        rd = mem[rd_idx];
        wr = mem[wr_idx];
        wr_hit = wr.valid && wr.tag == wr_tag;
        lookup_taken = rd.valid && rd.tag == rd_tag && rd.ctr[1];
        lookup_target = rd.target[PC_WIDTH-3:0];
    end

    // Only the valid bits are reset; the payload of an invalid entry is never used.
    // A not-taken miss leaves the entry alone, so it never allocates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) mem[i].valid <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < BTB_ENTRIES; i++) mem[i].valid <= 1'b0;
        end else if (update_valid && (wr_hit || update_taken)) begin
            mem[wr_idx] <= '{
                valid:  1'b1,
                tag:    wr_tag,
                target: update_taken ? FIELD_W'(update_target) : wr.target,
                ctr:    wr_hit ? sat_update(wr.ctr, update_taken) : CTR_WEAK_TAKEN
            };
        end
    end
endmodule

// File: rtl/jzjpcc_pc_btb.sv
// jzjpcc_pc_btb: fetch-stage program counter with BTB-based next-PC prediction.
//   clock, reset          : clock and asynchronous active-high reset
//   stall_fetch           : PC register holds (beats redirect)
//   redirect_valid/_pc    : execute-stage correction, highest nextPC priority
//   update_*              : resolved branch/jump used to train the BTB
//   flush_btb             : invalidate all BTB entries
//   currentPC_fetch       : registered fetch PC [PC_WIDTH-1:2]
//   nextPC                : combinational next PC for the memory address register
//   predicted_taken_fetch : BTB predicts currentPC_fetch taken
module jzjpcc_pc_btb
    import jzjpcc_fetch_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int BTB_ENTRIES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall_fetch,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-3:0] redirect_pc,
    input  logic                update_valid,
    input  logic [PC_WIDTH-3:0] update_pc,
    input  logic [PC_WIDTH-3:0] update_target,
    input  logic                update_taken,
    input  logic                flush_btb,
    output logic [PC_WIDTH-3:0] currentPC_fetch,
    output logic [PC_WIDTH-3:0] nextPC,
    output logic                predicted_taken_fetch
);
    logic [PC_WIDTH-3:0] pred_target;

    jzjpcc_btb #(.PC_WIDTH(PC_WIDTH), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
        .clock(clock),
        .reset(reset),
        .lookup_pc(currentPC_fetch),
        .lookup_taken(predicted_taken_fetch),
        .lookup_target(pred_target),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_target(update_target),
        .update_taken(update_taken),
        .flush(flush_btb)
    );

    // PC field starts at bit 2, so +1 here is +4 bytes; wraps silently.
    assign nextPC = redirect_valid ? redirect_pc
                  : predicted_taken_fetch ? pred_target
                  : currentPC_fetch + (PC_WIDTH-2)'(1);

    // A stalled redirect is not latched; the requester keeps redirect_valid up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) currentPC_fetch <= RESET_VECTOR[PC_WIDTH-1:2];
        else if (!stall_fetch) currentPC_fetch <= nextPC;
    end
endmodule

// File: tb/tb_jzjpcc_pc_btb.sv
// tb_jzjpcc_pc_btb: directed vector table plus randomized run against a byte-address reference model.
module tb_jzjpcc_pc_btb;
    localparam logic [31:0] RV = 32'h00001000;
    localparam int N = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic stall_fetch = 1'b0, redirect_valid = 1'b0, update_valid = 1'b0;
    logic update_taken = 1'b0, flush_btb = 1'b0;
    logic [29:0] redirect_pc = '0, update_pc = '0, update_target = '0;
    logic [29:0] currentPC_fetch, nextPC;
    logic predicted_taken_fetch;

    int checks = 0;
    int failures = 0;

    jzjpcc_pc_btb #(.PC_WIDTH(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
        .clock(clock),
        .reset(reset),
        .stall_fetch(stall_fetch),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_target(update_target),
        .update_taken(update_taken),
        .flush_btb(flush_btb),
        .currentPC_fetch(currentPC_fetch),
        .nextPC(nextPC),
        .predicted_taken_fetch(predicted_taken_fetch)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic stall, rv;
        logic [31:0] rpc;
        logic uv;
        logic [31:0] upc, utgt;
        logic ut, fl;
        logic [31:0] ecur, enext;
        logic epred;
    } vec_t;

    // Reference model in byte addresses: entry chosen by (pc/4) mod N, tag pc/(4N).
    bit m_valid [N];
    logic [31:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int m_ctr [N];
    logic [31:0] m_pc;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic m_pred(input logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && m_tag[i] == pc / (4 * N) && m_ctr[i] >= 2;
    endfunction

    function automatic logic [31:0] m_next(input logic rv, input logic [31:0] rpc);
        if (rv) return rpc;
        if (m_pred(m_pc)) return m_tgt[m_idx(m_pc)];
        return m_pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_pc = RV;
    endtask

    task automatic m_clock(input vec_t v);
        int i = m_idx(v.upc);
        bit hit = m_valid[i] && m_tag[i] == v.upc / (4 * N);
        if (!v.stall) m_pc = m_next(v.rv, v.rpc);
        if (v.fl) begin
            for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
        end else if (v.uv && hit) begin
            m_ctr[i] = v.ut ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
            if (v.ut) m_tgt[i] = v.utgt;
        end else if (v.uv && v.ut) begin
            m_valid[i] = 1'b1;
            m_tag[i] = v.upc / (4 * N);
            m_tgt[i] = v.utgt;
            m_ctr[i] = 2;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        stall_fetch = v.stall;
        redirect_valid = v.rv;
        redirect_pc = v.rpc[31:2];
        update_valid = v.uv;
        update_pc = v.upc[31:2];
        update_target = v.utgt[31:2];
        update_taken = v.ut;
        flush_btb = v.fl;
        @(negedge clock);
        chk({nm, ".cur"}, {currentPC_fetch, 2'b00}, v.ecur);
        chk({nm, ".next"}, {nextPC, 2'b00}, v.enext);
        chk({nm, ".pred"}, {31'd0, predicted_taken_fetch}, {31'd0, v.epred});
        @(posedge clock);
        m_clock(v);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                                input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                                input logic ut, input logic fl,
                                input logic [31:0] ecur, input logic [31:0] enext, input logic ep);
        vec_t v;
        v.stall = st; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc; v.utgt = utgt;
        v.ut = ut; v.fl = fl; v.ecur = ecur; v.enext = enext; v.epred = ep;
        return v;
    endfunction

    vec_t tbl [34];
    vec_t rv_;

    initial begin
        //           st rv rpc          uv upc      utgt     ut fl cur          next         pred
        tbl[0]  = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1000,    32'h1004,    0);
        tbl[1]  = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1004,    32'h1008,    0);
        tbl[2]  = mk(0, 0, 0,           1, 32'h1008, 32'h2000, 1, 0, 32'h1008,  32'h100C,    0);
        tbl[3]  = mk(0, 1, 32'h1000,    0, 0,       0,       0, 0, 32'h100C,    32'h1000,    0);
        tbl[4]  = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1000,    32'h1004,    0);
        tbl[5]  = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1004,    32'h1008,    0);
        tbl[6]  = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1008,    32'h2000,    1);
        tbl[7]  = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h2000,    32'h2004,    0);
        tbl[8]  = mk(0, 1, 32'h1008,    1, 32'h1008, 0,      0, 0, 32'h2004,    32'h1008,    0);
        tbl[9]  = mk(0, 0, 0,           1, 32'h1008, 0,      0, 0, 32'h1008,    32'h100C,    0);
        tbl[10] = mk(0, 1, 32'h1008,    1, 32'h1008, 32'h2000, 1, 0, 32'h100C,  32'h1008,    0);
        tbl[11] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1008,    32'h100C,    0);
        tbl[12] = mk(0, 0, 0,           1, 32'h1008, 32'h2000, 1, 0, 32'h100C,  32'h1010,    0);
        tbl[13] = mk(0, 0, 0,           1, 32'h1008, 32'h2000, 1, 0, 32'h1010,  32'h1014,    0);
        tbl[14] = mk(0, 0, 0,           1, 32'h1008, 32'h2000, 1, 0, 32'h1014,  32'h1018,    0);
        tbl[15] = mk(0, 1, 32'h1008,    1, 32'h1008, 32'h2000, 1, 0, 32'h1018,  32'h1008,    0);
        tbl[16] = mk(0, 0, 0,           1, 32'h1008, 0,      0, 0, 32'h1008,    32'h2000,    1);
        tbl[17] = mk(0, 1, 32'h1008,    0, 0,       0,       0, 0, 32'h2000,    32'h1008,    0);
        tbl[18] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1008,    32'h2000,    1);
        tbl[19] = mk(0, 1, 32'h1008,    0, 0,       0,       0, 0, 32'h2000,    32'h1008,    0);
        tbl[20] = mk(1, 1, 32'h3000,    0, 0,       0,       0, 0, 32'h1008,    32'h3000,    1);
        tbl[21] = mk(1, 1, 32'h3000,    0, 0,       0,       0, 0, 32'h1008,    32'h3000,    1);
        tbl[22] = mk(0, 1, 32'h3000,    0, 0,       0,       0, 0, 32'h1008,    32'h3000,    1);
        tbl[23] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h3000,    32'h3004,    0);
        tbl[24] = mk(0, 1, 32'h1008,    1, 32'h1048, 32'h4000, 1, 0, 32'h3004,  32'h1008,    0);
        tbl[25] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1008,    32'h100C,    0);
        tbl[26] = mk(0, 1, 32'h1048,    0, 0,       0,       0, 0, 32'h100C,    32'h1048,    0);
        tbl[27] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1048,    32'h4000,    1);
        tbl[28] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h4000,    32'h4004,    0);
        tbl[29] = mk(0, 1, 32'h1048,    1, 32'h1008, 32'h2000, 1, 1, 32'h4004,  32'h1048,    0);
        tbl[30] = mk(0, 1, 32'h1008,    0, 0,       0,       0, 0, 32'h1048,    32'h1008,    0);
        tbl[31] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'h1008,    32'h100C,    0);
        tbl[32] = mk(0, 1, 32'hFFFFFFFC, 0, 0,      0,       0, 0, 32'h100C,    32'hFFFFFFFC, 0);
        tbl[33] = mk(0, 0, 0,           0, 0,       0,       0, 0, 32'hFFFFFFFC, 32'h00000000, 0);

        m_reset();
        @(negedge clock);
        chk("reset.cur", {currentPC_fetch, 2'b00}, RV);
        chk("reset.next", {nextPC, 2'b00}, RV + 32'd4);
        chk("reset.pred", {31'd0, predicted_taken_fetch}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 34; i++) step(tbl[i], $sformatf("row%0d", i));

        // Asynchronous reset in the middle of a stalled redirect, between clock edges.
        stall_fetch = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 30'h00000C00;
        #2 reset = 1'b1;
        #1;
        chk("areset.cur", {currentPC_fetch, 2'b00}, RV);
        chk("areset.pred", {31'd0, predicted_taken_fetch}, 32'd0);
        redirect_valid = 1'b0;
        #1;
        chk("areset.next", {nextPC, 2'b00}, RV + 32'd4);
        @(posedge clock);
        #1;
        stall_fetch = 1'b0;
        reset = 1'b0;
        m_reset();

        for (int i = 0; i < 600; i++) begin
            rv_.stall = ($urandom_range(0, 7) == 0);
            rv_.rv = ($urandom_range(0, 7) == 0);
            rv_.rpc = 32'h1000 + ($urandom_range(0, 63) << 2);
            rv_.uv = $urandom_range(0, 1) == 1;
            rv_.upc = 32'h1000 + ($urandom_range(0, 63) << 2);
            rv_.utgt = 32'h1000 + ($urandom_range(0, 127) << 2);
            rv_.ut = $urandom_range(0, 2) != 0;
            rv_.fl = ($urandom_range(0, 63) == 0);
            rv_.ecur = m_pc;
            rv_.epred = m_pred(m_pc);
            rv_.enext = m_next(rv_.rv, rv_.rpc);
            step(rv_, $sformatf("rand%0d", i));
            // Keep the fetch PC inside the trained window so the BTB gets exercised.
            if (m_pc > 32'h1200 || m_pc < 32'h1000) begin
                rv_ = mk(0, 1, 32'h1000, 0, 0, 0, 0, 0, m_pc, 32'h1000, m_pred(m_pc));
                step(rv_, $sformatf("rand%0d.back", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
